seq_detect_ctrl: RTL and testbench

- Programmable bit-serial sequence detector with controller FSM.
- Host loads a pattern of 1..MAX_LEN bits, arms a scan over a window of N accepted bits, and reads back a match count and done pulse.
- Sits between a bit-stream source and the lab's sequence-detection datapath, replacing fixed-pattern detectors with one configurable, sequenced block.

---
 rtl/seq_detect_pkg.sv | 22 ++
 rtl/seq_match_core.sv | 52 +++++
 rtl/seq_detect_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types, default sizes and the pattern-length mask helper for the sequence detector.
// Optional feature macro: SEQ_DETECT_OVERLAP_EN (overlapping matches count).
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_WIN_W   = 16;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Low 'len' bits set; callers truncate to their pattern width.
    function automatic logic [31:0] len_mask(input logic [31:0] len);
        if (len >= 32'd32) return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern comparator.
// With SEQ_DETECT_OVERLAP_EN defined, history/fill survive a match; otherwise fill restarts.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               bit_in,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_sat;
    logic [LEN_W:0]     fill_inc;

    assign hist_nxt = (hist_q << 1) | MAX_LEN'(bit_in);
    assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign fill_sat = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_inc[LEN_W-1:0];
    assign mask     = MAX_LEN'(len_mask(32'(len)));

    // Evaluated against the history as it will be after this bit shifts in.
    assign hit = shift_en && (fill_inc >= {1'b0, len}) &&
                 (((hist_nxt ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_nxt;
`ifdef SEQ_DETECT_OVERLAP_EN
            fill_q <= fill_sat;
`else
            fill_q <= hit ? '0 : fill_sat;
`endif
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable bit-serial sequence detector: config handshake, scan FSM, window and match counters.
// Optional feature macro: SEQ_DETECT_OVERLAP_EN (handled inside seq_match_core).
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               start,
    input  logic [WIN_W-1:0]   window,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               err
);

    state_t             state_q, state_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               cfg_ok_q;
    logic [WIN_W-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               match_q;
    logic               err_q;

    logic cfg_fire, len_ok, arm, shift_en, hit;

    assign cfg_fire = (state_q == IDLE) && cfg_valid;
    assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // A config handshake in IDLE takes precedence over start in the same cycle.
    always_comb begin
        state_nxt = state_q;
        arm       = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cfg_valid && start && cfg_ok_q) begin
                    arm       = 1'b1;
                    state_nxt = (window == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (rem_q == WIN_W'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= '0;
            len_q    <= '0;
            cfg_ok_q <= 1'b0;
            rem_q    <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            match_q <= shift_en && hit;
            if (cfg_fire) begin
                if (len_ok) begin
                    pat_q    <= cfg_pattern;
                    len_q    <= cfg_len;
                    cfg_ok_q <= 1'b1;
                    err_q    <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if ((state_q == IDLE) && start && !cfg_ok_q) begin
                err_q <= 1'b1;
            end
            if (arm) begin
                cnt_q <= '0;
                rem_q <= window;
            end
            if (shift_en) begin
                rem_q <= rem_q - WIN_W'(1);
                if (hit && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clr      (arm),
        .bit_in   (bit_in),
        .len      (len_q),
        .pattern  (pat_q),
        .hit      (hit)
    );

    assign cfg_ready   = (state_q == IDLE) && rst_n;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign match       = match_q;
    assign match_count = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl plus hand-written multi-cycle sequences.
// Expectations follow SEQ_DETECT_OVERLAP_EN when the bench is built with it.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int WIN_W   = 16;
    localparam int CNT_W   = 8;
`ifdef SEQ_DETECT_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               start = 1'b0;
    logic [WIN_W-1:0]   window = '0;
    logic               abort = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_in = 1'b0;
    logic               busy, match, done, err;
    logic [CNT_W-1:0]   match_count;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .WIN_W   (WIN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .start       (start),
        .window      (window),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic        rst, cv;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        st;
        logic [15:0] win;
        logic        ab, bv, bi;
        logic        busy, match, done;
        logic [7:0]  cnt;
        logic        err, rdy;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rst, cv, pat, len, st, win, ab, bv, bi,
                                input int e_busy, e_match, e_done, e_cnt, e_err, e_rdy);
        vec_t v;
        v.rst = 1'(rst);  v.cv = 1'(cv);  v.pat = 8'(pat);  v.len = 4'(len);
        v.st = 1'(st);    v.win = 16'(win); v.ab = 1'(ab);  v.bv = 1'(bv);  v.bi = 1'(bi);
        v.busy = 1'(e_busy); v.match = 1'(e_match); v.done = 1'(e_done);
        v.cnt = 8'(e_cnt);   v.err = 1'(e_err);     v.rdy = 1'(e_rdy);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic arm(input logic [15:0] win);
        start = 1'b1; window = win;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int   pulses;
        logic got_done;
        int   bits[8] = '{0, 1, 1, 0, 1, 0, 1, 0};

        // rst cv pat len st win ab bv bi | busy match done cnt err rdy
        // Reset and overlap stream 0,1,1,0,1,0,1,0 against 1010
        tbl.push_back(mk(1,0,8'h00,0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 0,0,0,0,0,1));
        tbl.push_back(mk(0,1,8'h0A,4,0,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,8,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 1,1,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 0,OVL,1,1+OVL,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,1+OVL,0,1));
        // Bad config leaves the config invalid; start then errors
        tbl.push_back(mk(1,0,8'h00,0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,1,8'h00,0,0,0,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,8'hFF,9,0,0,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,8'h00,0,1,5,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,0,1,1));
        tbl.push_back(mk(0,1,8'h05,3,0,0,0,0,0, 0,0,0,0,0,1));
        // Window of zero goes straight to DONE
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,0,0,1));
        // Window of three, final bit matches: match and done together
        tbl.push_back(mk(0,1,8'h07,3,0,0,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,3,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 0,1,1,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,1,0,1));
        // Abort after one match, with a would-be match on the abort cycle
        tbl.push_back(mk(0,0,8'h00,0,1,8,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,1,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 1,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,1, 1,0,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1,1,1, 0,0,0,1,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,1,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,4,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1,0,0, 0,0,0,0,0,1));
        // Config and start together: config wins, no err; start held while busy is ignored
        tbl.push_back(mk(0,1,8'h01,1,1,5,0,0,0, 0,0,0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,2,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,9,0,1,1, 1,1,0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,1,9,0,1,1, 0,1,1,2,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,2,0,1));

        foreach (tbl[i]) begin
            rst_n = ~tbl[i].rst;  cfg_valid = tbl[i].cv;  cfg_pattern = tbl[i].pat;
            cfg_len = tbl[i].len; start = tbl[i].st;      window = tbl[i].win;
            abort = tbl[i].ab;    bit_valid = tbl[i].bv;  bit_in = tbl[i].bi;
            tick();
            chk($sformatf("v%0d.busy", i),  32'(busy),        32'(tbl[i].busy));
            chk($sformatf("v%0d.match", i), 32'(match),       32'(tbl[i].match));
            chk($sformatf("v%0d.done", i),  32'(done),        32'(tbl[i].done));
            chk($sformatf("v%0d.cnt", i),   32'(match_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.err", i),   32'(err),         32'(tbl[i].err));
            chk($sformatf("v%0d.rdy", i),   32'(cfg_ready),   32'(tbl[i].rdy));
        end
        cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        rst_n = 1'b1;

        // Same 1010 stream with 0..3-cycle bit_valid gaps
        load_cfg(8'h0A, 4'd4);
        arm(16'd8);
        pulses = 0; got_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < i % 4; g++) begin
                bit_valid = 1'b0; bit_in = 1'b1;
                tick();
                pulses += int'(match); got_done |= done;
            end
            bit_valid = 1'b1; bit_in = 1'(bits[i]);
            tick();
            pulses += int'(match); got_done |= done;
        end
        bit_valid = 1'b0;
        chk("gap.pulses", 32'(pulses), 32'(1 + OVL));
        chk("gap.done", 32'(got_done), 32'd1);
        chk("gap.cnt", 32'(match_count), 32'(1 + OVL));
        tick();

        // 300 single-bit matches: count saturates, pulses keep firing
        load_cfg(8'h01, 4'd1);
        arm(16'd300);
        pulses = 0; got_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
            pulses += int'(match); got_done |= done;
        end
        bit_valid = 1'b0;
        chk("sat.pulses", 32'(pulses), 32'd300);
        chk("sat.done", 32'(got_done), 32'd1);
        chk("sat.cnt", 32'(match_count), 32'd255);
        tick();
        chk("sat.hold", 32'(match_count), 32'd255);

        // Reset mid-RUN while a match pulse is showing
        arm(16'd10);
        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("rst.pre_match", 32'(match), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.match", 32'(match), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.cnt", 32'(match_count), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdy", 32'(cfg_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        arm(16'd3);
        chk("rst.cfg_invalid_err", 32'(err), 32'd1);
        chk("rst.cfg_invalid_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
